// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared constants and IF/ID control encoding for the fetch stage
package instruction_fetch_pkg;

  localparam int          INSTR_W  = 32;
  localparam int          ADDR_W   = 32;
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    IFID_LOAD  = 2'b00,
    IFID_HOLD  = 2'b01,
    IFID_FLUSH = 2'b10,
    IFID_FAULT = 2'b11
  } ifid_op_e;

  // Instruction fetches are word aligned; the low two address bits are dropped.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register with load, hold, flush and fault-load controls
module if_id_register
  import instruction_fetch_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  ifid_op_e           op,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [ADDR_W-1:0]  pc_plus4,
  output logic [INSTR_W-1:0] if_id_instruction,
  output logic [ADDR_W-1:0]  if_id_pc_plus4,
  output logic               if_id_valid,
  output logic               fetch_fault
);

  always_ff @(posedge clock) begin
    if (reset) begin
      if_id_instruction <= MIPS_NOP;
      if_id_pc_plus4    <= '0;
      if_id_valid       <= 1'b0;
      fetch_fault       <= 1'b0;
    end else begin
      unique case (op)
        IFID_LOAD: begin
          if_id_instruction <= instruction;
          if_id_pc_plus4    <= pc_plus4;
          if_id_valid       <= 1'b1;
          fetch_fault       <= 1'b0;
        end
        IFID_FLUSH: begin
          if_id_instruction <= MIPS_NOP;
          if_id_pc_plus4    <= '0;
          if_id_valid       <= 1'b0;
          fetch_fault       <= 1'b0;
        end
        // Out-of-range fetch: keep the slot as a bubble but flag it for decode.
        IFID_FAULT: begin
          if_id_instruction <= MIPS_NOP;
          if_id_pc_plus4    <= pc_plus4;
          if_id_valid       <= 1'b0;
          fetch_fault       <= 1'b1;
        end
        default: begin
          if_id_instruction <= if_id_instruction;
          if_id_pc_plus4    <= if_id_pc_plus4;
          if_id_valid       <= if_id_valid;
          fetch_fault       <= fetch_fault;
        end
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS fetch stage: pc register, next-pc priority mux and range check
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instruction,
  output logic [31:0] pc,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_fault
);

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic        in_range;
  ifid_op_e    ifid_op;

  assign imem_addr = {2'b00, pc[31:2]};
  assign pc_plus4  = pc + PC_STEP;
  assign in_range  = pc[31:2] < IMEM_LIMIT;

  // Branch resolves in EX, so it is older than a jump in ID and wins; any redirect beats a stall.
  always_comb begin
    pc_next = pc_plus4;
    ifid_op = in_range ? IFID_LOAD : IFID_FAULT;
    if (branch_taken) begin
      pc_next = word_align(branch_target);
      ifid_op = IFID_FLUSH;
    end else if (jump) begin
      pc_next = word_align(jump_target);
      ifid_op = IFID_FLUSH;
    end else if (stall) begin
      pc_next = pc;
      ifid_op = IFID_HOLD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= word_align(RESET_PC);
    end else begin
      pc <= pc_next;
    end
  end

  if_id_register u_if_id (
    .clock             (clock),
    .reset             (reset),
    .op                (ifid_op),
    .instruction       (imem_instruction),
    .pc_plus4          (pc_plus4),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid),
    .fetch_fault       (fetch_fault)
  );

endmodule
